rv32i_mc_controller: RTL and testbench
======================================

# rv32i_mc_controller

Multicycle RV32I control unit: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one unified memory port. It replaces the combinational single-cycle controller in the multicycle datapath. It drives the existing ALU/immediate/load-extend encodings and branch flags unchanged. It adds a memory-ready handshake and illegal-opcode trapping.

## Interface
- USE_MEM_READY, 1: 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = memory is single-cycle and mem_ready is ignored.
- ILLEGAL_HALT, 1: 1 = an illegal opcode parks the FSM in TRAP until reset; 0 = the instruction is skipped (PC+4) and fetch continues.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction register [6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- Zero, NEG, NEGU  in  1 each  ALU flags from the current-cycle ALU result.
- mem_ready  in  1  memory completes the current request.
- MemReq  out  1  memory access valid.
- MemWrite  out  1  store strobe.
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  latch IR and OldPC.
- PCWrite  out  1  PC load enable.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  2  operand A: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  operand B: 00 = rs2, 01 = Imm, 10 = constant 4.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  3  immediate type: I = 000, S = 001, B = 010, U = 011, J = 100.
- ALUControl  out  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- LoadExtSrc  out  3  funct3, passed through.
- Illegal  out  1  sticky illegal-opcode flag, cleared only by reset.
- state_o  out  4  current state, for debug.

## Operation
- Reset (rst_n = 0, asynchronous): the state goes to FETCH. Illegal = 0. All registered outputs are 0.
- In FETCH the controller outputs are: MemReq = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ADD, ResultSrc = 10.
  - IRWrite and PCWrite are asserted only in the cycle the fetch completes. That is the mem_ready = 1 cycle, or the first cycle when USE_MEM_READY = 0.
  - The FSM then moves to DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = B, ADD, so ALUOut = OldPC + imm. The FSM dispatches on opcode:
  - 0000011 → MEMADR (load)
  - 0100011 → MEMADR (store)
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 and 0010111 → UPPER
  - any other opcode → ILLEGAL handling
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ADD. ImmSrc = I for loads, S for stores. The FSM goes to MEMREAD for loads and MEMWRITE for stores.
- MEMREAD: MemReq = 1, AdrSrc = 1. It holds until the access completes, then goes to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWRITE: MemReq = 1, MemWrite = 1, AdrSrc = 1. It holds until the access completes, then goes to FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, then ALUWB.
  - funct3 → op mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - funct3 000 with funct7_5 = 1 selects SUB.
  - funct3 101 with funct7_5 = 1 selects SRA.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = I, then ALUWB.
  - The funct3 mapping is the same as EXECR, but funct3 000 is always ADD.
  - funct3 101 uses funct7_5 to choose SRA.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, SUB, ResultSrc = 00. Then FETCH.
  - PCWrite = taken, evaluated combinationally in this cycle.
  - Taken per funct3: 000 Zero; 001 !Zero; 100 NEG; 101 !NEG; 110 NEGU; 111 !NEGU.
  - funct3 010 and 011 are never taken.
- JAL: ImmSrc = J in DECODE instead of B. PCWrite = 1 with ResultSrc = 00 (target). ALUSrcA = 01, ALUSrcB = 10, ADD, so ALUOut = OldPC + 4. Then ALUWB.
- JALR: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = I, ADD, ResultSrc = 10, PCWrite = 1. Then LINK.
- LINK: ALUSrcA = 01, ALUSrcB = 10, ADD, then ALUWB.
- UPPER: ImmSrc = U, ALUSrcB = 01, ADD, then ALUWB.
  - ALUSrcA = 11 for LUI.
  - ALUSrcA = 01 for AUIPC.
- ILLEGAL handling: Illegal is set to 1.
  - ILLEGAL_HALT = 1: the FSM enters TRAP and all enables stay 0 until reset.
  - ILLEGAL_HALT = 0: the FSM returns to FETCH. PC+4 was already written in FETCH.
- Default outputs: every output not listed for a state is 0. ImmSrc defaults to I and ALUControl defaults to ADD.

## Timing
- The state register updates on the rising edge of clk.
- Decoded outputs are combinational from state, opcode, funct3 and funct7_5. PCWrite in BRANCH also depends on the flags.
- Cycles per instruction with zero wait states:
  - load 5
  - store 4
  - R/I-type 4
  - branch 3
  - JAL 4
  - JALR 5
  - LUI/AUIPC 4
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs are held stable while waiting.
- mem_ready asserted outside a MemReq state is ignored.
- Reset asserted mid-instruction aborts it immediately. No partial RegWrite, PCWrite or MemWrite survives past the reset edge.
- After rst_n rises, the first FETCH cycle issues MemReq = 1.

## Test plan
- Reset → fetch: hold rst_n = 0, then release it with mem_ready = 1. Required: state_o = FETCH, MemReq = 1, IRWrite = 1 and PCWrite = 1 in the same cycle.
- add x3, x1, x2 (opcode 0110011, funct3 000, funct7_5 0) → state sequence FETCH, DECODE, EXECR, ALUWB. Required: ALUControl = 0000 in EXECR; RegWrite = 1 only in ALUWB.
- lw with USE_MEM_READY = 1 and mem_ready low for 2 cycles in MEMREAD → total 7 cycles. Required: MemReq = 1 and AdrSrc = 1 held throughout MEMREAD; ResultSrc = 01 in MEMWB.
- bne with Zero = 0 → PCWrite = 1 in BRANCH. bne with Zero = 1 → PCWrite = 0. bltu with NEGU = 1 → PCWrite = 1.
- Illegal opcode 0000000:
  - ILLEGAL_HALT = 1: Illegal = 1 and the FSM stays in TRAP for 20 or more cycles.
  - ILLEGAL_HALT = 0: the next cycle is FETCH.
- jalr → FETCH, DECODE, JALR (PCWrite = 1, ResultSrc = 10), LINK, ALUWB (RegWrite = 1). Asserting rst_n = 0 during LINK forces FETCH with RegWrite = 0.

Source files
------------

// File: rtl/rv32i_mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, with mem_ready stalls and illegal-opcode trapping.
module rv32i_mc_controller #(
   parameter bit USE_MEM_READY = 1'b1,
   parameter bit ILLEGAL_HALT  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       Zero,
   input  logic       NEG,
   input  logic       NEGU,
   input  logic       mem_ready,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic [2:0] LoadExtSrc,
   output logic       Illegal,
   output logic [3:0] state_o
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LINK     = 4'd12,
      S_UPPER    = 4'd13,
      S_TRAP     = 4'd14
   } state_e;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   mem_done;
   logic   br_taken;

   // Register-register and register-immediate ops share the funct3 map; only R-type may SUB.
   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f75, input logic is_r);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_r && f75) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f75 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   assign mem_done = USE_MEM_READY ? mem_ready : 1'b1;

   always_comb begin
      case (funct3)
         3'b000:  br_taken = Zero;
         3'b001:  br_taken = ~Zero;
         3'b100:  br_taken = NEG;
         3'b101:  br_taken = ~NEG;
         3'b110:  br_taken = NEGU;
         3'b111:  br_taken = ~NEGU;
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ImmSrc     = IMM_I;
      ALUControl = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            MemReq    = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_done;
            PCWrite   = mem_done;
            if (mem_done) state_d = S_DECODE;
         end
         // Branch target (or JAL target) is precomputed into ALUOut here.
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI, OP_AUIPC:  state_d = S_UPPER;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = ILLEGAL_HALT ? S_TRAP : S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
            if (mem_done) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            MemReq   = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
            if (mem_done) state_d = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_dec(funct3, funct7_5, 1'b1);
            state_d    = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec(funct3, funct7_5, 1'b0);
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            PCWrite    = br_taken;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            PCWrite = 1'b1;
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            state_d   = S_LINK;
         end
         S_LINK: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = S_ALUWB;
         end
         S_UPPER: begin
            ALUSrcA = (opcode == OP_LUI) ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = IMM_U;
            state_d = S_ALUWB;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   assign LoadExtSrc = funct3;
   assign Illegal    = illegal_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Directed, table-driven bench for rv32i_mc_controller: one instance with ready handshake
// and halting trap, one with single-cycle memory and skip-on-illegal.
module tb_rv32i_mc_controller;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_L    = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                          S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                          S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                          S_LINK = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd14;

   // Enable bundle order: MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite
   localparam logic [5:0] EN_0  = 6'b000000;
   localparam logic [5:0] EN_F  = 6'b100110;
   localparam logic [5:0] EN_FW = 6'b100000;
   localparam logic [5:0] EN_RW = 6'b000001;
   localparam logic [5:0] EN_PC = 6'b000010;
   localparam logic [5:0] EN_MR = 6'b101000;
   localparam logic [5:0] EN_MW = 6'b111000;

   typedef struct packed {
      logic [3:0] st;
      logic [5:0] en;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] res;
      logic [2:0] imm;
      logic [3:0] alu;
      logic [2:0] lext;
      logic       ill;
   } ctl_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f75;
      logic       z, n, nu, rdy;
      ctl_t       exp;
   } vec_t;

   logic       clk, rst_a_n, rst_b_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, Zero, NEG, NEGU, mem_ready;

   logic       mr_a, mw_a, as_a, irw_a, pcw_a, rw_a, ill_a;
   logic [1:0] sa_a, sb_a, rs_a;
   logic [2:0] imm_a, lx_a;
   logic [3:0] alu_a, st_a;
   logic       mr_b, mw_b, as_b, irw_b, pcw_b, rw_b, ill_b;
   logic [1:0] sa_b, sb_b, rs_b;
   logic [2:0] imm_b, lx_b;
   logic [3:0] alu_b, st_b;
   ctl_t       oa, ob;

   int   checks = 0;
   int   errors = 0;
   logic ill_now = 1'b0;
   vec_t tbl[$];

   rv32i_mc_controller #(.USE_MEM_READY(1'b1), .ILLEGAL_HALT(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .Zero(Zero), .NEG(NEG), .NEGU(NEGU), .mem_ready(mem_ready),
      .MemReq(mr_a), .MemWrite(mw_a), .AdrSrc(as_a), .IRWrite(irw_a), .PCWrite(pcw_a),
      .RegWrite(rw_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ResultSrc(rs_a), .ImmSrc(imm_a),
      .ALUControl(alu_a), .LoadExtSrc(lx_a), .Illegal(ill_a), .state_o(st_a));

   rv32i_mc_controller #(.USE_MEM_READY(1'b0), .ILLEGAL_HALT(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .Zero(Zero), .NEG(NEG), .NEGU(NEGU), .mem_ready(mem_ready),
      .MemReq(mr_b), .MemWrite(mw_b), .AdrSrc(as_b), .IRWrite(irw_b), .PCWrite(pcw_b),
      .RegWrite(rw_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ResultSrc(rs_b), .ImmSrc(imm_b),
      .ALUControl(alu_b), .LoadExtSrc(lx_b), .Illegal(ill_b), .state_o(st_b));

   always_comb begin
      oa = {st_a, mr_a, mw_a, as_a, irw_a, pcw_a, rw_a, sa_a, sb_a, rs_a, imm_a, alu_a, lx_a, ill_a};
      ob = {st_b, mr_b, mw_b, as_b, irw_b, pcw_b, rw_b, sa_b, sb_b, rs_b, imm_b, alu_b, lx_b, ill_b};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic ctl_t mk(input logic [3:0] st, input logic [5:0] en, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] res, input logic [2:0] imm,
                               input logic [3:0] alu, input logic [2:0] f3, input logic ill);
      return {st, en, a, b, res, imm, alu, f3, ill};
   endfunction

   task automatic p(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                    input logic z, input logic n, input logic nu, input logic rdy,
                    input logic [3:0] st, input logic [5:0] en, input logic [1:0] a,
                    input logic [1:0] b, input logic [1:0] res, input logic [2:0] imm,
                    input logic [3:0] alu);
      vec_t v;
      v.op = op; v.f3 = f3; v.f75 = f75; v.z = z; v.n = n; v.nu = nu; v.rdy = rdy;
      v.exp = mk(st, en, a, b, res, imm, alu, f3, ill_now);
      tbl.push_back(v);
   endtask

   task automatic pf(input logic [6:0] op, input logic [2:0] f3, input logic f75);
      p(op, f3, f75, 0, 0, 0, 1, S_FETCH, EN_F, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000);
   endtask
   task automatic pd(input logic [6:0] op, input logic [2:0] f3, input logic f75);
      p(op, f3, f75, 0, 0, 0, 1, S_DECODE, EN_0, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000);
   endtask
   task automatic pw(input logic [6:0] op, input logic [2:0] f3, input logic f75);
      p(op, f3, f75, 0, 0, 0, 1, S_ALUWB, EN_RW, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
   endtask

   // Apply each row just after a rising edge, compare mid-cycle, then advance one clock.
   task automatic run(input bit sel);
      for (int i = 0; i < tbl.size(); i++) begin
         opcode = tbl[i].op; funct3 = tbl[i].f3; funct7_5 = tbl[i].f75;
         Zero = tbl[i].z; NEG = tbl[i].n; NEGU = tbl[i].nu; mem_ready = tbl[i].rdy;
         #3;
         chk($sformatf("%s_row%0d", sel ? "b" : "a", i), 32'(sel ? ob : oa), 32'(tbl[i].exp));
         @(posedge clk); #1;
      end
      tbl.delete();
   endtask

   task automatic instr_r(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                          input logic [3:0] st, input logic [1:0] b, input logic [3:0] alu);
      pf(op, f3, f75); pd(op, f3, f75);
      p(op, f3, f75, 0, 0, 0, 1, st, EN_0, 2'b10, b, 2'b00, 3'b000, alu);
      pw(op, f3, f75);
   endtask

   task automatic instr_br(input logic [2:0] f3, input logic z, input logic n, input logic nu,
                           input logic [5:0] en);
      pf(OP_B, f3, 0); pd(OP_B, f3, 0);
      p(OP_B, f3, 0, z, n, nu, 1, S_BRANCH, en, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001);
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      opcode = '0; funct3 = '0; funct7_5 = 1'b0;
      Zero = 1'b0; NEG = 1'b0; NEGU = 1'b0; mem_ready = 1'b1;
      #2;
      chk("reset_a", 32'({st_a, ill_a}), 32'(5'b0));
      chk("reset_b", 32'({st_b, ill_b}), 32'(5'b0));

      // ALU ops: add, sub, sra, and, addi(f7_5=1), srai, ori
      instr_r(OP_R, 3'b000, 0, S_EXECR, 2'b00, 4'b0000);
      instr_r(OP_R, 3'b000, 1, S_EXECR, 2'b00, 4'b0001);
      instr_r(OP_R, 3'b101, 1, S_EXECR, 2'b00, 4'b1001);
      instr_r(OP_R, 3'b111, 0, S_EXECR, 2'b00, 4'b0010);
      instr_r(OP_I, 3'b000, 1, S_EXECI, 2'b01, 4'b0000);
      instr_r(OP_I, 3'b101, 1, S_EXECI, 2'b01, 4'b1001);
      instr_r(OP_I, 3'b110, 0, S_EXECI, 2'b01, 4'b0011);
      // lw with two wait states in MEMREAD
      pf(OP_L, 3'b010, 0); pd(OP_L, 3'b010, 0);
      p(OP_L, 3'b010, 0, 0, 0, 0, 1, S_MEMADR, EN_0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000);
      p(OP_L, 3'b010, 0, 0, 0, 0, 0, S_MEMREAD, EN_MR, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      p(OP_L, 3'b010, 0, 0, 0, 0, 0, S_MEMREAD, EN_MR, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      p(OP_L, 3'b010, 0, 0, 0, 0, 1, S_MEMREAD, EN_MR, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      p(OP_L, 3'b010, 0, 0, 0, 0, 1, S_MEMWB, EN_RW, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000);
      // sw with a wait state in FETCH and one in MEMWRITE
      p(OP_S, 3'b010, 0, 0, 0, 0, 0, S_FETCH, EN_FW, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000);
      pf(OP_S, 3'b010, 0); pd(OP_S, 3'b010, 0);
      p(OP_S, 3'b010, 0, 0, 0, 0, 1, S_MEMADR, EN_0, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000);
      p(OP_S, 3'b010, 0, 0, 0, 0, 0, S_MEMWRITE, EN_MW, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      p(OP_S, 3'b010, 0, 0, 0, 0, 1, S_MEMWRITE, EN_MW, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      // branches: bne Z=0, bne Z=1, bltu NEGU=1, funct3 011 never taken, blt NEG=0
      instr_br(3'b001, 0, 0, 0, EN_PC);
      instr_br(3'b001, 1, 0, 0, EN_0);
      instr_br(3'b110, 0, 0, 1, EN_PC);
      instr_br(3'b011, 1, 1, 1, EN_0);
      instr_br(3'b100, 1, 0, 1, EN_0);
      // jal
      pf(OP_JAL, 3'b000, 0);
      p(OP_JAL, 3'b000, 0, 0, 0, 0, 1, S_DECODE, EN_0, 2'b01, 2'b01, 2'b00, 3'b100, 4'b0000);
      p(OP_JAL, 3'b000, 0, 0, 0, 0, 1, S_JAL, EN_PC, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000);
      pw(OP_JAL, 3'b000, 0);
      // jalr full
      pf(OP_JALR, 3'b000, 0); pd(OP_JALR, 3'b000, 0);
      p(OP_JALR, 3'b000, 0, 0, 0, 0, 1, S_JALR, EN_PC, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000);
      p(OP_JALR, 3'b000, 0, 0, 0, 0, 1, S_LINK, EN_0, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000);
      pw(OP_JALR, 3'b000, 0);
      // lui / auipc
      pf(OP_LUI, 3'b000, 0); pd(OP_LUI, 3'b000, 0);
      p(OP_LUI, 3'b000, 0, 0, 0, 0, 1, S_UPPER, EN_0, 2'b11, 2'b01, 2'b00, 3'b011, 4'b0000);
      pw(OP_LUI, 3'b000, 0);
      pf(OP_AUI, 3'b000, 0); pd(OP_AUI, 3'b000, 0);
      p(OP_AUI, 3'b000, 0, 0, 0, 0, 1, S_UPPER, EN_0, 2'b01, 2'b01, 2'b00, 3'b011, 4'b0000);
      pw(OP_AUI, 3'b000, 0);
      // jalr stopped at LINK by reset below
      pf(OP_JALR, 3'b000, 0); pd(OP_JALR, 3'b000, 0);
      p(OP_JALR, 3'b000, 0, 0, 0, 0, 1, S_JALR, EN_PC, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000);

      @(posedge clk); #1;
      rst_a_n = 1'b1;
      run(1'b0);

      // Reset during LINK aborts the writeback
      opcode = OP_JALR; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
      #2;
      chk("link_state", 32'(st_a), 32'(S_LINK));
      rst_a_n = 1'b0;
      #1;
      chk("rst_mid_state", 32'(st_a), 32'(S_FETCH));
      chk("rst_mid_regwrite", 32'({rw_a, mw_a}), 32'(2'b00));
      @(posedge clk); #1;
      chk("rst_edge_state", 32'(st_a), 32'(S_FETCH));
      chk("rst_edge_regwrite", 32'({rw_a, mw_a}), 32'(2'b00));
      rst_a_n = 1'b1;

      // Illegal opcode with halt: park in TRAP regardless of mem_ready
      opcode = 7'b0000000; funct3 = 3'b000;
      #3;
      chk("ill_fetch", 32'({st_a, ill_a}), 32'({S_FETCH, 1'b0}));
      @(posedge clk); #1; #3;
      chk("ill_decode", 32'({st_a, ill_a}), 32'({S_DECODE, 1'b0}));
      @(posedge clk); #1;
      for (int i = 0; i < 22; i++) begin
         mem_ready = i[0];
         #3;
         chk($sformatf("trap%0d", i), 32'(oa),
             32'(mk(S_TRAP, EN_0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000, 1'b1)));
         @(posedge clk); #1;
      end
      rst_a_n = 1'b0;
      #1;
      chk("trap_reset", 32'({st_a, ill_a}), 32'({S_FETCH, 1'b0}));

      // Single-cycle memory, skip-on-illegal instance; mem_ready held low throughout
      ill_now = 1'b0;
      p(7'b0000000, 3'b000, 0, 0, 0, 0, 0, S_FETCH, EN_F, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000);
      p(7'b0000000, 3'b000, 0, 0, 0, 0, 0, S_DECODE, EN_0, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000);
      ill_now = 1'b1;
      p(OP_L, 3'b100, 0, 0, 0, 0, 0, S_FETCH, EN_F, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000);
      p(OP_L, 3'b100, 0, 0, 0, 0, 0, S_DECODE, EN_0, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000);
      p(OP_L, 3'b100, 0, 0, 0, 0, 0, S_MEMADR, EN_0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000);
      p(OP_L, 3'b100, 0, 0, 0, 0, 0, S_MEMREAD, EN_MR, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      p(OP_L, 3'b100, 0, 0, 0, 0, 0, S_MEMWB, EN_RW, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000);
      p(OP_S, 3'b000, 0, 0, 0, 0, 0, S_FETCH, EN_F, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000);
      p(OP_S, 3'b000, 0, 0, 0, 0, 0, S_DECODE, EN_0, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000);
      p(OP_S, 3'b000, 0, 0, 0, 0, 0, S_MEMADR, EN_0, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000);
      p(OP_S, 3'b000, 0, 0, 0, 0, 0, S_MEMWRITE, EN_MW, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
      p(OP_S, 3'b000, 0, 0, 0, 0, 0, S_FETCH, EN_F, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000);
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      run(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
